// File: rtl/seg_frame_shifter_pkg.sv
// seg_frame_pkg: shared state encoding, frame geometry and a frame-building helper for the display link.
package seg_frame_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_e;
    localparam int FRAME_W = 24;
    localparam int RED_LSB = 16;
    localparam int GRN_LSB = 8;
    localparam int LED_LSB = 0;
    localparam int FIELD_W = 7;
    function automatic logic [FRAME_W-1:0] mk_frame(input logic [FIELD_W-1:0] red, grn, led);
        mk_frame = '0;
        mk_frame[RED_LSB +: FIELD_W] = red;
        mk_frame[GRN_LSB +: FIELD_W] = grn;
        mk_frame[LED_LSB +: FIELD_W] = led;
    endfunction
endpackage

// File: rtl/seg_frame_shifter_if.sv
// seg_frame_shifter_if: valid/ready frame handshake from the formatting logic into the shifter.
interface seg_frame_shifter_if;
    import seg_frame_pkg::*;
    logic [FRAME_W-1:0] in_frame;
    logic               in_valid;
    logic               in_ready;
    modport master (output in_frame, in_valid, input in_ready);
    modport slave  (input in_frame, in_valid, output in_ready);
endinterface

// File: rtl/seg_frame_shifter_half_tick.sv
// seg_half_tick: loadable down-counter giving a one-cycle tick at the end of each CLK_DIV-cycle dwell.
module seg_half_tick
    import seg_frame_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       tick,
    output logic       tick_next
);
    logic [7:0] cnt_q, cnt_d;
    assign tick      = cnt_q == 8'd0;
    assign tick_next = cnt_d == 8'd0;
    always_comb begin
        cnt_d = load ? load_val : (tick ? 8'(CLK_DIV - 1) : cnt_q - 8'd1);
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/seg_frame_shifter.sv
// seg_frame_shifter: buffers one 24-bit display frame and shifts it MSB-first on sclk/sdata, then strobes latch.
// Optional SEG_FRAME_COALESCE_EN: in_ready stays high and a newer frame overwrites the pending one (latest wins).
module seg_frame_shifter
    import seg_frame_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    seg_frame_shifter_if.slave  up,
    output logic                sclk,
    output logic                sdata,
    output logic                latch,
    output logic                busy,
    output logic                frame_done,
    output logic                dropped
);
    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    state_e             state_q, state_d;
    logic [FRAME_W-1:0] pend_q, pend_d, sh_q, sh_d;
    logic [4:0]         bit_q, bit_d;
    logic               pend_v_q, pend_v_d;
    logic               sclk_q, sclk_d, sdata_q, sdata_d, latch_q, latch_d;
    logic               busy_q, busy_d, done_q, done_d, drop_q, drop_d;
    logic               tick, tick_next, accept, load_pend, ht_load;
    logic [7:0]         ht_val;
`ifdef SEG_FRAME_COALESCE_EN
    assign up.in_ready = 1'b1;
`else
    assign up.in_ready = !pend_v_q;
`endif
    assign accept = up.in_valid && up.in_ready;
    // Divider restarts on every state entry; IDLE parks it at zero so a pending frame starts next edge.
    assign ht_load = (state_d != state_q) || (state_d == IDLE);
    assign ht_val  = (state_d == IDLE) ? 8'd0 : DIV_M1;
    seg_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .load      (ht_load),
        .load_val  (ht_val),
        .tick      (tick),
        .tick_next (tick_next)
    );
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        load_pend = 1'b0;
        case (state_q)
            IDLE:     load_pend = tick && pend_v_q;
            SHIFT_LO: state_d = tick ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: if (tick) begin
                if (bit_q == 5'd23) state_d = LATCH;
                else begin
                    sh_d    = sh_q << 1;
                    bit_d   = bit_q + 5'd1;
                    state_d = SHIFT_LO;
                end
            end
            LATCH:    state_d = tick ? GAP : LATCH;
            GAP:      if (tick) begin
                load_pend = pend_v_q;
                state_d   = IDLE;
            end
            default:  state_d = IDLE;
        endcase
        if (load_pend) begin
            state_d = SHIFT_LO;
            sh_d    = pend_q;
            bit_d   = '0;
        end
        pend_d   = accept ? up.in_frame : pend_q;
        pend_v_d = accept || (pend_v_q && !load_pend);
        sclk_d   = state_d == SHIFT_HI;
        latch_d  = state_d == LATCH;
        // Data is updated one clock after sclk falls, giving CLK_DIV-1 cycles of setup.
        sdata_d  = (state_q == SHIFT_LO) ? sh_q[FRAME_W-1] : ((state_q == SHIFT_HI) && sdata_q);
        busy_d   = (state_d != IDLE) || pend_v_d;
        done_d   = (state_d == LATCH) && tick_next;
`ifdef SEG_FRAME_COALESCE_EN
        drop_d   = accept && pend_v_q && !load_pend;
`else
        drop_d   = 1'b0;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            sh_q     <= '0;
            bit_q    <= '0;
            pend_v_q <= 1'b0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            pend_v_q <= pend_v_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end
    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign latch      = latch_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign dropped    = drop_q;
endmodule
